// File: rtl/priority_grant_sequencer.sv
// Batch grant sequencer: snapshots a request vector on load and issues one grant
// per handshake, either highest-index-first or round-robin below the last grant.
module priority_grant_sequencer #(
  parameter int N    = 12,
  parameter int IDXW = 4
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic [N:1]      req_i,
  input  logic            load_i,
  input  logic            rr_mode_i,
  input  logic            flush_i,
  input  logic            grant_ready_i,
  output logic            grant_valid_o,
  output logic [IDXW-1:0] grant_idx_o,
  output logic [N:1]      grant_onehot_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [IDXW-1:0] pending_count_o
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t          state_q, state_d;
  logic [N:1]      pending_q, pending_d;
  logic [IDXW-1:0] last_idx_q, last_idx_d;
  logic            mode_q, mode_d;
  logic            done_q, done_d;

  logic [IDXW-1:0] hi_all, hi_below, sel;
  logic [N:1]      sel_oh;
  logic [IDXW-1:0] cnt;
  logic            xfer;

  // Ascending scan so the last hit is the highest set bit; last_idx=0 admits every bit.
  always_comb begin
    hi_all   = '0;
    hi_below = '0;
    cnt      = '0;
    for (int i = 1; i <= N; i++) begin
      cnt = cnt + IDXW'(pending_q[i]);
      if (pending_q[i]) begin
        hi_all = IDXW'(i);
        if (last_idx_q == '0 || IDXW'(i) < last_idx_q) hi_below = IDXW'(i);
      end
    end
    sel = (mode_q && hi_below != '0) ? hi_below : hi_all;
  end

  always_comb begin
    grant_valid_o = (state_q == SERVE) && (pending_q != '0);
    sel_oh        = '0;
    for (int i = 1; i <= N; i++) sel_oh[i] = (sel == IDXW'(i));
    grant_idx_o     = grant_valid_o ? sel : '0;
    grant_onehot_o  = grant_valid_o ? sel_oh : '0;
    busy_o          = (state_q == SERVE);
    done_o          = done_q;
    pending_count_o = cnt;
    xfer            = grant_valid_o && grant_ready_i;
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    last_idx_d = last_idx_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          if (req_i != '0) begin
            pending_d = req_i;
            mode_d    = rr_mode_i;
            state_d   = SERVE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SERVE: begin
        // flush wins over a same-cycle transfer: nothing is granted
        if (flush_i) begin
          pending_d = '0;
          state_d   = IDLE;
        end else if (xfer) begin
          pending_d  = pending_q & ~sel_oh;
          last_idx_d = sel;
          if ((pending_q & ~sel_oh) == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      last_idx_q <= '0;
      mode_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      last_idx_q <= last_idx_d;
      mode_q     <= mode_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_priority_grant_sequencer.sv
// Bench: directed scenarios with literal expectations, then random traffic, all
// checked every cycle against a queue-free behavioural scheduler model.
module tb_priority_grant_sequencer;
  localparam int N = 12;
  localparam int IDXW = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N:1]      req;
  logic            load, rr_mode, flush, grant_ready;
  logic            grant_valid, busy, done;
  logic [IDXW-1:0] grant_idx, pending_count;
  logic [N:1]      grant_onehot;

  int vectors = 0;
  int miscompares = 0;

  priority_grant_sequencer #(.N(N), .IDXW(IDXW)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .req_i(req), .load_i(load),
    .rr_mode_i(rr_mode), .flush_i(flush), .grant_ready_i(grant_ready),
    .grant_valid_o(grant_valid), .grant_idx_o(grant_idx),
    .grant_onehot_o(grant_onehot), .busy_o(busy), .done_o(done),
    .pending_count_o(pending_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: a set of pending indices plus a bookmark.
  bit m_pend [1:N];
  bit m_busy, m_mode, m_done, m_ok;
  int m_last;

  function automatic int m_sel();
    int j, c;
    if (!m_mode) begin
      for (int i = N; i >= 1; i--) if (m_pend[i]) return i;
      return 0;
    end
    // circular walk starting just below the bookmark (bookmark 0 = start at N)
    j = (m_last == 0) ? N + 1 : m_last;
    for (int k = 1; k <= N; k++) begin
      c = j - k;
      if (c < 1) c += N;
      if (m_pend[c]) return c;
    end
    return 0;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 1; i <= N; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int s, v;
    if (!m_ok) return;
    v = (m_busy && m_count() != 0) ? 1 : 0;
    s = v ? m_sel() : 0;
    chk("model.grant_valid", int'(grant_valid), v);
    chk("model.grant_idx", int'(grant_idx), s);
    chk("model.grant_onehot", int'(grant_onehot), (s == 0) ? 0 : (1 << (s - 1)));
    chk("model.busy", int'(busy), int'(m_busy));
    chk("model.done", int'(done), int'(m_done));
    chk("model.pending_count", int'(pending_count), m_count());
  endtask

  task automatic model_update();
    bit nd = 0;
    int s;
    if (!reset_n) begin
      for (int i = 1; i <= N; i++) m_pend[i] = 0;
      m_busy = 0; m_mode = 0; m_last = 0; m_done = 0; m_ok = 1;
      return;
    end
    if (!m_busy) begin
      if (load) begin
        if (req != '0) begin
          for (int i = 1; i <= N; i++) m_pend[i] = req[i];
          m_mode = rr_mode;
          m_busy = 1;
        end else nd = 1;
      end
    end else if (flush) begin
      for (int i = 1; i <= N; i++) m_pend[i] = 0;
      m_busy = 0;
    end else if (grant_ready) begin
      s = m_sel();
      m_pend[s] = 0;
      m_last = s;
      if (m_count() == 0) begin
        m_busy = 0;
        nd = 1;
      end
    end
    m_done = nd;
  endtask

  // One clock: compare at negedge, advance model on posedge, return at next negedge.
  task automatic cyc();
    check_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_in();
    load = 0; flush = 0; grant_ready = 0; rr_mode = 0; req = '0; reset_n = 1;
  endtask

  task automatic do_load(input logic [N:1] r, input logic rr, input logic rdy);
    req = r; rr_mode = rr; load = 1; grant_ready = rdy;
    cyc();
    load = 0; req = '0;
  endtask

  int exp_seq[4];

  initial begin
    idle_in();
    reset_n = 0;
    m_ok = 0;
    @(negedge clk);
    cyc(); cyc();
    chk("reset.valid", int'(grant_valid), 0);
    chk("reset.count", int'(pending_count), 0);
    chk("reset.busy", int'(busy), 0);
    reset_n = 1;
    cyc();

    // Fixed-priority batch
    exp_seq = '{12, 8, 5, 1};
    do_load(12'h891, 0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t1.idx", int'(grant_idx), exp_seq[i]);
      chk("t1.count", int'(pending_count), 4 - i);
      cyc();
    end
    chk("t1.done", int'(done), 1);
    chk("t1.valid_off", int'(grant_valid), 0);
    cyc();
    chk("t1.done_clear", int'(done), 0);

    // Flush during grant 8 keeps bookmark at 12
    do_load(12'h891, 0, 1);
    cyc();
    chk("t5.idx8", int'(grant_idx), 8);
    flush = 1;
    cyc();
    flush = 0;
    chk("t5.busy", int'(busy), 0);
    chk("t5.count", int'(pending_count), 0);
    chk("t5.done", int'(done), 0);
    chk("t5.last", m_last, 12);
    cyc();
    chk("t5.done_late", int'(done), 0);

    // Backpressure on grant 12
    do_load(12'h891, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t3.idx_held", int'(grant_idx), 12);
      chk("t3.oh_held", int'(grant_onehot), 12'h800);
      chk("t3.count_held", int'(pending_count), 4);
      cyc();
    end
    grant_ready = 1;
    cyc();
    chk("t3.next", int'(grant_idx), 8);
    cyc();
    chk("t3.after8", int'(grant_idx), 5);
    flush = 1;
    cyc();
    flush = 0;

    // Round-robin from bookmark 8
    exp_seq = '{5, 1, 12, 8};
    do_load(12'h891, 1, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t2.idx", int'(grant_idx), exp_seq[i]);
      cyc();
    end
    chk("t2.done", int'(done), 1);
    cyc();

    // Empty load
    do_load(12'h000, 0, 1);
    chk("t4.done", int'(done), 1);
    chk("t4.valid", int'(grant_valid), 0);
    chk("t4.busy", int'(busy), 0);
    cyc();
    chk("t4.done_clear", int'(done), 0);

    // Reset mid-batch, then RR batch from bookmark 0
    do_load(12'h891, 0, 1);
    cyc();
    reset_n = 0;
    cyc();
    reset_n = 1;
    chk("t6.valid", int'(grant_valid), 0);
    chk("t6.idx", int'(grant_idx), 0);
    chk("t6.count", int'(pending_count), 0);
    do_load(12'h003, 1, 1);
    chk("t6.first", int'(grant_idx), 2);
    cyc();
    chk("t6.second", int'(grant_idx), 1);
    cyc();
    chk("t6.done", int'(done), 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset_n     = ($urandom_range(0, 99) != 0);
      load        = ($urandom_range(0, 3) == 0);
      rr_mode     = $urandom_range(0, 1);
      flush       = ($urandom_range(0, 19) == 0);
      grant_ready = ($urandom_range(0, 2) != 0);
      req         = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      cyc();
    end
    idle_in();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
